// File: rtl/quic_enc_run_pkg.sv
// Shared definitions for the QUIC MELCODE run path (encoder and decoder).
// Holds the melstate -> melclen table so both sides adapt identically.
package quic_enc_run_pkg;

  localparam int RUN_W      = 16;
  localparam int MEL_STATES = 32;
  localparam int MEL_W      = 5;
  localparam int CLEN_W     = 4;
  localparam int CORDER_W   = 17;
  localparam int CODE_W     = 16;
  localparam int CODE_LEN_W = 5;

  typedef enum logic {
    ENC_RUN_IDLE   = 1'b0,
    ENC_RUN_ACTIVE = 1'b1
  } enc_run_state_e;

  // J table: 0-15 step every 4 states, 16-23 step every 2, 24-31 step every state.
  function automatic logic [CLEN_W-1:0] mel_clen(input logic [MEL_W-1:0] ms);
    logic [CLEN_W-1:0] clen;
    clen = '0;
    if (ms < 5'd16) begin
      clen = {2'b00, ms[3:2]};
    end else if (ms < 5'd24) begin
      clen = 4'd4 + {2'b00, ms[2:1]};
    end else begin
      clen = ms[3:0];
    end
    return clen;
  endfunction

endpackage

// File: rtl/quic_mel_table.sv
// Combinational melstate -> (melclen, melcorder) lookup, shared with the decoder.
module quic_mel_table
  import quic_enc_run_pkg::*;
(
  input  logic [MEL_W-1:0]    melstate,
  output logic [CLEN_W-1:0]   melclen,
  output logic [CORDER_W-1:0] melcorder
);

  assign melclen   = mel_clen(melstate);
  // melcorder is 17 bits wide so 1<<15 and comparisons against a full 16-bit rem fit.
  assign melcorder = CORDER_W'(1) << melclen;

endmodule

// File: rtl/quic_enc_run.sv
// MELCODE run-length encoder: emits one hit code per melcorder chunk of the run,
// then one miss code carrying the residual, adapting melstate as it goes.
module quic_enc_run
  import quic_enc_run_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mel_clear,
  input  logic                  run_start,
  input  logic [RUN_W-1:0]      run_len_in,
  output logic                  run_ready,
  output logic                  code_valid,
  input  logic                  code_ready,
  output logic [CODE_W-1:0]     code_bits,
  output logic [CODE_LEN_W-1:0] code_len,
  output logic                  run_done,
  output logic [MEL_W-1:0]      melstate
);

  localparam logic [MEL_W-1:0] MEL_MAX = MEL_W'(MEL_STATES - 1);

  enc_run_state_e       state_q, state_d;
  logic [RUN_W-1:0]     rem_q, rem_d;
  logic [MEL_W-1:0]     mel_q, mel_d;
  logic [CLEN_W-1:0]    melclen;
  logic [CORDER_W-1:0]  melcorder;
  logic                 hit;

  quic_mel_table u_mel_table (
    .melstate  (mel_q),
    .melclen   (melclen),
    .melcorder (melcorder)
  );

  // Hit/miss depends only on registered rem and melstate, so it is stable under stall.
  assign hit      = {1'b0, rem_q} >= melcorder;
  assign melstate = mel_q;

  // State, residual and mel state registers.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ENC_RUN_IDLE;
      rem_q   <= '0;
      mel_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      mel_q   <= mel_d;
    end
  end

  // Next-state and code outputs; mel_clear overrides any handshake or run_start.
  always_comb begin
    // NOTE: every output and next-state value gets a default first, so no path infers a latch.
    state_d    = state_q;
    rem_d      = rem_q;
    mel_d      = mel_q;
    run_ready  = 1'b0;
    code_valid = 1'b0;
    code_bits  = '0;
    code_len   = '0;
    run_done   = 1'b0;

    case (state_q)
      ENC_RUN_IDLE: begin
        run_ready = 1'b1;
        if (run_start) begin
          rem_d   = run_len_in;
          state_d = ENC_RUN_ACTIVE;
        end
      end
      ENC_RUN_ACTIVE: begin
        code_valid = 1'b1;
        if (hit) begin
          code_bits = CODE_W'(1);
          code_len  = CODE_LEN_W'(1);
        end else begin
          // rem < melcorder, so rem already is the residual with a leading zero bit.
          code_bits = CODE_W'(rem_q);
          code_len  = {1'b0, melclen} + CODE_LEN_W'(1);
        end
        if (code_ready) begin
          if (hit) begin
            rem_d = rem_q - melcorder[RUN_W-1:0];
            if (mel_q < MEL_MAX) mel_d = mel_q + MEL_W'(1);
          end else begin
            if (mel_q != '0) mel_d = mel_q - MEL_W'(1);
            run_done = 1'b1;
            state_d  = ENC_RUN_IDLE;
          end
        end
      end
      default: state_d = ENC_RUN_IDLE;
    endcase

    if (mel_clear) begin
      mel_d    = '0;
      rem_d    = rem_q;
      state_d  = ENC_RUN_IDLE;
      run_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_quic_enc_run.sv
// Directed self-checking bench for quic_enc_run with hand-computed code sequences.
module tb_quic_enc_run;

  logic        clk;
  logic        reset_n;
  logic        mel_clear;
  logic        run_start;
  logic [15:0] run_len_in;
  logic        run_ready;
  logic        code_valid;
  logic        code_ready;
  logic [15:0] code_bits;
  logic [4:0]  code_len;
  logic        run_done;
  logic [4:0]  melstate;

  int n_checks = 0;
  int n_fail   = 0;

  quic_enc_run dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mel_clear  (mel_clear),
    .run_start  (run_start),
    .run_len_in (run_len_in),
    .run_ready  (run_ready),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_bits  (code_bits),
    .code_len   (code_len),
    .run_done   (run_done),
    .melstate   (melstate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    mel_clear = 1'b1;
    @(negedge clk);
    mel_clear = 1'b0;
  endtask

  // Runs one run and checks every offered code: nhits hits of (1,len1), then the miss.
  // stall_a/stall_b: code index held off for 3 cycles (-1 = none).
  // poke: drive a conflicting run_start on the first ACTIVE cycle.
  task automatic do_run(input string name, input logic [15:0] len, input int ms0,
                        input int nhits, input logic [15:0] miss_bits,
                        input logic [4:0] miss_len, input int ms_end,
                        input int stall_a, input int stall_b, input bit poke);
    int  idx, cyc, stall_cnt, last_stall, exp_ms, exp_cyc;
    bit  done, rdy, exp_hit;
    idx = 0; cyc = 0; stall_cnt = 0; last_stall = -1; done = 1'b0;
    @(negedge clk);
    check({name, " start_ms"}, 32'(melstate), 32'(ms0));
    check({name, " ready_idle"}, 32'(run_ready), 32'd1);
    run_start  = 1'b1;
    run_len_in = len;
    code_ready = 1'b0;
    @(negedge clk);
    run_start = 1'b0;
    cyc = 1;
    while (!done && cyc < 400) begin
      if ((idx == stall_a || idx == stall_b) && last_stall != idx) begin
        stall_cnt  = 3;
        last_stall = idx;
      end
      rdy = (stall_cnt == 0);
      if (stall_cnt > 0) stall_cnt--;
      if (poke && cyc == 1) begin
        run_start  = 1'b1;
        run_len_in = 16'd100;
      end
      code_ready = rdy;
      #1;
      exp_hit = (idx < nhits);
      exp_ms  = ms0 + idx;
      if (exp_ms > 31) exp_ms = 31;
      check({name, " valid"}, 32'(code_valid), 32'd1);
      check({name, " busy"}, 32'(run_ready), 32'd0);
      check({name, " bits"}, 32'(code_bits), exp_hit ? 32'd1 : 32'(miss_bits));
      check({name, " len"}, 32'(code_len), exp_hit ? 32'd1 : 32'(miss_len));
      check({name, " ms"}, 32'(melstate), 32'(exp_ms));
      check({name, " done"}, 32'(run_done), 32'(rdy && !exp_hit));
      if (rdy) begin
        idx++;
        if (!exp_hit) done = 1'b1;
      end
      @(negedge clk);
      run_start = 1'b0;
      cyc++;
    end
    check({name, " finished"}, 32'(done), 32'd1);
    exp_cyc = nhits + 2 + (stall_a >= 0 ? 3 : 0) + (stall_b >= 0 ? 3 : 0);
    check({name, " cycles"}, 32'(cyc), 32'(exp_cyc));
    check({name, " ready_after"}, 32'(run_ready), 32'd1);
    check({name, " valid_after"}, 32'(code_valid), 32'd0);
    check({name, " done_after"}, 32'(run_done), 32'd0);
    check({name, " end_ms"}, 32'(melstate), 32'(ms_end));
    code_ready = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    mel_clear  = 1'b0;
    run_start  = 1'b0;
    run_len_in = '0;
    code_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst ready", 32'(run_ready), 32'd1);
    check("rst valid", 32'(code_valid), 32'd0);
    check("rst bits", 32'(code_bits), 32'd0);
    check("rst len", 32'(code_len), 32'd0);
    check("rst done", 32'(run_done), 32'd0);
    check("rst ms", 32'(melstate), 32'd0);
    reset_n = 1'b1;

    // Basic run: 3 hits at melclen 0, then miss (0,len1).
    do_run("run3", 16'd3, 0, 3, 16'h0000, 5'd1, 2, -1, -1, 1'b0);

    // Zero-length run: single miss, ready back after 2 cycles.
    pulse_clear();
    do_run("run0", 16'd0, 0, 0, 16'h0000, 5'd1, 0, -1, -1, 1'b0);

    // Walk melstate to 3, then run of 6 crosses into melclen 1.
    do_run("run4", 16'd4, 0, 4, 16'h0000, 5'd2, 3, -1, -1, 1'b0);
    do_run("run6", 16'd6, 3, 3, 16'h0001, 5'd2, 5, -1, -1, 1'b0);

    // Maximum run: 31 hits to melstate 31, then a 16-bit miss; then saturation.
    pulse_clear();
    do_run("max1", 16'hFFFF, 0, 31, 16'h7EE3, 5'd16, 30, -1, -1, 1'b0);
    do_run("max2", 16'hFFFF, 30, 2, 16'h3FFF, 5'd16, 30, -1, -1, 1'b0);

    // Backpressure on the second hit and on the miss.
    pulse_clear();
    do_run("stall", 16'd3, 0, 3, 16'h0000, 5'd1, 2, 1, 3, 1'b0);

    // mel_clear on the 2nd hit of a run of 10, with code_ready high (clear wins).
    pulse_clear();
    @(negedge clk);
    run_start  = 1'b1;
    run_len_in = 16'd10;
    @(negedge clk);
    run_start  = 1'b0;
    code_ready = 1'b1;
    @(negedge clk);
    check("clr ms_before", 32'(melstate), 32'd1);
    check("clr valid_before", 32'(code_valid), 32'd1);
    mel_clear = 1'b1;
    #1;
    check("clr no_done", 32'(run_done), 32'd0);
    @(negedge clk);
    mel_clear  = 1'b0;
    code_ready = 1'b0;
    check("clr ms", 32'(melstate), 32'd0);
    check("clr idle", 32'(run_ready), 32'd1);
    check("clr valid", 32'(code_valid), 32'd0);
    check("clr done", 32'(run_done), 32'd0);

    // mel_clear beats run_start in IDLE.
    run_start  = 1'b1;
    run_len_in = 16'd5;
    mel_clear  = 1'b1;
    @(negedge clk);
    run_start = 1'b0;
    mel_clear = 1'b0;
    check("clr_vs_start ready", 32'(run_ready), 32'd1);
    check("clr_vs_start valid", 32'(code_valid), 32'd0);

    // run_start while ACTIVE must be ignored.
    do_run("poke", 16'd3, 0, 3, 16'h0000, 5'd1, 2, -1, -1, 1'b1);

    // Reset mid-run returns to reset values immediately.
    @(negedge clk);
    run_start  = 1'b1;
    run_len_in = 16'd5;
    code_ready = 1'b1;
    @(negedge clk);
    run_start = 1'b0;
    @(negedge clk);
    check("midrst ms_before", 32'(melstate), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst ms", 32'(melstate), 32'd0);
    check("midrst ready", 32'(run_ready), 32'd1);
    check("midrst valid", 32'(code_valid), 32'd0);
    check("midrst bits", 32'(code_bits), 32'd0);
    check("midrst len", 32'(code_len), 32'd0);
    @(negedge clk);
    code_ready = 1'b0;
    reset_n    = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
